// File: rtl/fomu_touch_pkg.sv
// Shared definitions for the Fomu touch-pad reader.
// Contents: event type codes, per-pad FSM state encoding, pending-flag slot
// indices and a counter-width helper that never returns zero.
package fomu_touch_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_RELEASE = 2'b10;
    localparam logic [1:0] EVT_LONG    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } pad_state_e;

    // Slot order inside a pad's pending vector; lower slot = higher priority.
    localparam int P_PRESS = 0;
    localparam int P_LONG  = 1;
    localparam int P_REL   = 2;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/touch_debounce.sv
// Single-pad synchroniser and debouncer.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   pad       raw pad level, asynchronous, active-low (0 = touched)
//   stable    debounced level, 1 = touched
//   rise      one-cycle pulse, combinational: stable goes 0->1 at the next edge
//   fall      one-cycle pulse, combinational: stable goes 1->0 at the next edge
module touch_debounce
    import fomu_touch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 48000
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          sample;
    logic [CW-1:0] cnt;
    logic          flip;

    // Synchroniser resets to the released level so no spurious press follows reset.
    always_ff @(posedge clk) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], pad};
    end

    assign sample = ~sync[1];
    assign flip   = (sample != stable) && (cnt == CNT_MAX);
    assign rise   = flip & ~stable;
    assign fall   = flip &  stable;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sample == stable) begin
            cnt    <= '0;
        end else if (flip) begin
            cnt    <= '0;
            stable <= ~stable;
        end else begin
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fomu_touch_reader.sv
// Fomu touch-pad reader: debounces each pad, classifies press / release /
// long-press, queues one pending flag per event kind per pad and issues them
// one at a time over a valid/ready stream.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   pad_i        raw pad levels, active-low
//   pressed_o    debounced levels, 1 = pressed
//   evt_valid_o  event available; evt_ready_i accepts it
//   evt_pad_o    pad index of the event
//   evt_type_o   01 press, 10 release, 11 long press
//   evt_drop_o   sticky overflow indicator, cleared only by rst
// Build option: define TOUCH_LONG_PRESS_EN to include the LONG state, the hold
// counter and long-press events; otherwise LONG_PRESS_CYCLES is ignored.
module fomu_touch_reader
    import fomu_touch_pkg::*;
#(
    parameter int N_PADS            = 4,
    parameter int DEBOUNCE_CYCLES   = 48000,
    parameter int LONG_PRESS_CYCLES = 24000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_PADS-1:0]            pad_i,
    output logic [N_PADS-1:0]            pressed_o,
    output logic                         evt_valid_o,
    input  logic                         evt_ready_i,
    output logic [cnt_width(N_PADS)-1:0] evt_pad_o,
    output logic [1:0]                   evt_type_o,
    output logic                         evt_drop_o
);

    localparam int PW = cnt_width(N_PADS);

    logic [N_PADS-1:0]      stable, rise, fall;
    logic [N_PADS-1:0][2:0] set_evt;   // flags raised by the FSMs this cycle
    logic [N_PADS-1:0][2:0] pend;
    logic [N_PADS-1:0][2:0] sel_clr;   // flag the selector would take
    logic [N_PADS-1:0][2:0] take;      // flag actually taken this cycle
    logic                   sel_any;
    logic [PW-1:0]          sel_pad;
    logic [1:0]             sel_type;
    logic                   load;

    assign pressed_o = stable;

    for (genvar p = 0; p < N_PADS; p++) begin : g_pad
        pad_state_e state, state_nxt;
        logic       s_press, s_long, s_rel;

        touch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk    (clk),
            .rst    (rst),
            .pad    (pad_i[p]),
            .stable (stable[p]),
            .rise   (rise[p]),
            .fall   (fall[p])
        );

`ifdef TOUCH_LONG_PRESS_EN
        localparam int HW = cnt_width(LONG_PRESS_CYCLES);
        logic [HW-1:0] hold;
        logic          hold_done;

        assign hold_done = (hold == HW'(LONG_PRESS_CYCLES - 1));

        // Held at zero while idle, so it starts from zero on press acceptance;
        // frozen in LONG so only one long event can occur per press.
        always_ff @(posedge clk) begin
            if (rst || state == ST_IDLE) hold <= '0;
            else if (state == ST_PRESSED) hold <= hold + 1'b1;
        end
`else
        logic unused_long_cfg;
        assign unused_long_cfg = (LONG_PRESS_CYCLES != 0);
`endif

        always_ff @(posedge clk) begin
            if (rst) state <= ST_IDLE;
            else     state <= state_nxt;
        end

        always_comb begin
            state_nxt = state;
            s_press   = 1'b0;
            s_long    = 1'b0;
            s_rel     = 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise[p]) begin
                        state_nxt = ST_PRESSED;
                        s_press   = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (fall[p]) begin
                        state_nxt = ST_IDLE;
                        s_rel     = 1'b1;
                    end
`ifdef TOUCH_LONG_PRESS_EN
                    else if (hold_done) begin
                        state_nxt = ST_LONG;
                        s_long    = 1'b1;
                    end
                end
                ST_LONG: begin
                    if (fall[p]) begin
                        state_nxt = ST_IDLE;
                        s_rel     = 1'b1;
                    end
`endif
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        assign set_evt[p] = {s_rel, s_long, s_press};
    end

    // Lowest pad wins (loop runs high to low so the last hit is kept);
    // within a pad press > long > release, matching causal order.
    always_comb begin
        sel_any  = 1'b0;
        sel_pad  = '0;
        sel_type = EVT_PRESS;
        sel_clr  = '0;
        for (int p = N_PADS - 1; p >= 0; p--) begin
            if (|pend[p]) begin
                sel_any = 1'b1;
                sel_pad = PW'(p);
                sel_clr = '0;
                if (pend[p][P_PRESS]) begin
                    sel_type             = EVT_PRESS;
                    sel_clr[p][P_PRESS]  = 1'b1;
                end else if (pend[p][P_LONG]) begin
                    sel_type             = EVT_LONG;
                    sel_clr[p][P_LONG]   = 1'b1;
                end else begin
                    sel_type             = EVT_RELEASE;
                    sel_clr[p][P_REL]    = 1'b1;
                end
            end
        end
    end

    assign load = ~evt_valid_o | evt_ready_i;

    always_comb begin
        take = '0;
        if (load) take = sel_clr;
    end

    // A flag taken this cycle frees its slot, so a new instance in the same
    // cycle is kept rather than counted as a drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend       <= '0;
            evt_drop_o <= 1'b0;
        end else begin
            pend <= (pend & ~take) | set_evt;
            if (|(set_evt & pend & ~take)) evt_drop_o <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid_o <= 1'b0;
            evt_pad_o   <= '0;
            evt_type_o  <= 2'b00;
        end else if (load) begin
            evt_valid_o <= sel_any;
            if (sel_any) begin
                evt_pad_o  <= sel_pad;
                evt_type_o <= sel_type;
            end
        end
    end

endmodule
